// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
//   Shared encodings for the execute stage: ALU-op and funct codes, the
//   internal ALU control enum, the stage FSM states and the funct decoder.
// ----------------------------------------------------------------------------
package ex_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b000000;
    localparam logic [5:0] FUNCT_MUL = 6'b000001;
    localparam logic [5:0] FUNCT_SUB = 6'b000010;
    localparam logic [5:0] FUNCT_AND = 6'b000011;
    localparam logic [5:0] FUNCT_OR  = 6'b000100;
    localparam logic [5:0] FUNCT_SLT = 6'b000101;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FULL
    } state_t;

    typedef struct packed {
        alu_ctrl_t ctrl;
        logic      illegal;
    } alu_dec_t;

    // Unknown R-type functs fall back to ADD but are flagged.
    function automatic alu_dec_t alu_decode(input logic [1:0] alu_op,
                                            input logic [5:0] funct);
        alu_dec_t d;
        d.ctrl    = ALU_ADD;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: d.ctrl = ALU_ADD;
            ALUOP_BEQ: d.ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.ctrl = ALU_ADD;
                    FUNCT_SUB: d.ctrl = ALU_SUB;
                    FUNCT_MUL: d.ctrl = ALU_MUL;
                    FUNCT_AND: d.ctrl = ALU_AND;
                    FUNCT_OR:  d.ctrl = ALU_OR;
                    FUNCT_SLT: d.ctrl = ALU_SLT;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.ctrl = ALU_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// ----------------------------------------------------------------------------
// ex_iter_mul
//   Iterative shift-add multiplier retiring MUL_BITS multiplier bits per
//   cycle; only the low DATA_W bits of the unsigned product are kept.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     start        load a/b and begin (ignored while kill is high)
//     kill         abort any multiplication in progress
//     a, b         multiplicand, multiplier
//     done         high in the cycle whose edge performs the last step
//     product      product value valid while done is high
// ----------------------------------------------------------------------------
module ex_iter_mul #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int MUL_CYC = DATA_W / MUL_BITS;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYC - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] acc_next;

    // The multiplicand is pre-shifted each step, so partial products line
    // up with the accumulator without tracking the bit position.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    assign acc_next = acc_q + partial;
    assign done     = run_q && (cnt_q == LAST);
    assign product  = acc_next;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (run_q) begin
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            acc_d    = acc_next;
            cnt_d    = cnt_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
            end
        end
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end
        if (kill) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

endmodule

// File: rtl/ex_stage_mc.sv
// ----------------------------------------------------------------------------
// ex_stage_mc
//   Execute stage between the ID and MEM registers with valid/ready on both
//   sides. Computes ALU result, zero flag, destination register and branch
//   target; MUL ops run on an iterative multiplier and stall ID while busy.
//   Ports:
//     clk, reset, flush                 clock, sync reset, sync kill
//     in_valid/in_ready                 ID-side handshake
//     pc, rs, rt, sign_ext              op operands (sign_ext[5:0] = funct)
//     alu_src, alu_op, branch, reg_dst  decoded controls
//     rt_addr, rd_addr                  destination candidates
//     out_valid/out_ready               MEM-side handshake
//     result, zero, branch_taken,
//     branch_target, pc_out, rd_out,
//     illegal_op                        registered output beat
//     busy                              multiplier iterating
// ----------------------------------------------------------------------------
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic              branch,
    input  logic              reg_dst,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] pc_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              illegal_op,
    output logic              busy
);

    // Everything in the output beat except the result itself.
    typedef struct packed {
        logic              zero;
        logic              taken;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] pc_out;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } beat_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    beat_t             beat_q, beat_d;
    beat_t             pend_q, pend_d;

    alu_dec_t          dec;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] alu_res;
    beat_t             beat_new;
    logic              is_mul;
    logic              accept;
    logic              ld_new;
    logic              ld_mul;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign dec   = alu_decode(alu_op, sign_ext[5:0]);
    // Loads/stores/addi always take the immediate regardless of alu_src.
    assign data2 = (alu_op == ALUOP_MEM || alu_src) ? sign_ext : rt;

    always_comb begin
        alu_res = rs + data2;
        case (dec.ctrl)
            ALU_ADD: alu_res = rs + data2;
            ALU_SUB: alu_res = rs - data2;
            ALU_AND: alu_res = rs & data2;
            ALU_OR:  alu_res = rs | data2;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs) < $signed(data2))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        beat_new.zero    = (rs == data2);
        beat_new.taken   = branch && beat_new.zero;
        beat_new.target  = pc + (sign_ext << 2);
        beat_new.pc_out  = beat_new.taken ? beat_new.target : pc;
        beat_new.rd      = reg_dst ? rd_addr : rt_addr;
        beat_new.illegal = dec.illegal;
    end

    assign is_mul    = (dec.ctrl == ALU_MUL);
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign ld_new    = accept && !is_mul;
    assign mul_start = accept && is_mul;
    assign ld_mul    = (state_q == MUL) && mul_done && !flush;

    ex_iter_mul #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .kill    (flush),
        .a       (rs),
        .b       (data2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        beat_d   = beat_q;
        pend_d   = pend_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? MUL : FULL;
            MUL:  if (mul_done) state_d = FULL;
            FULL: if (out_ready) state_d = accept ? (is_mul ? MUL : FULL) : IDLE;
            default: state_d = IDLE;
        endcase
        if (ld_new) begin
            result_d = alu_res;
            beat_d   = beat_new;
        end else if (ld_mul) begin
            result_d = mul_product;
            beat_d   = pend_q;
        end
        // Side fields of a MUL op wait here so they surface with the product.
        if (mul_start) begin
            pend_d = beat_new;
        end
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            beat_q   <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign out_valid     = (state_q == FULL);
    assign busy          = (state_q == MUL);
    assign result        = result_q;
    assign zero          = beat_q.zero;
    assign branch_taken  = beat_q.taken;
    assign branch_target = beat_q.target;
    assign pc_out        = beat_q.pc_out;
    assign rd_out        = beat_q.rd;
    assign illegal_op    = beat_q.illegal;

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready;
    logic [DW-1:0] pc, rs, rt, sign_ext;
    logic          alu_src, branch, reg_dst;
    logic [1:0]    alu_op;
    logic [AW-1:0] rt_addr, rd_addr;
    logic          out_valid, out_ready;
    logic [DW-1:0] result, branch_target, pc_out;
    logic          zero, branch_taken, illegal_op, busy;
    logic [AW-1:0] rd_out;

    logic          or_drv;
    logic          rnd_bp;
    logic          bp_rand;

    always #5 clk = ~clk;

    assign out_ready = rnd_bp ? bp_rand : or_drv;

    ex_stage_mc #(.DATA_W(DW), .MUL_BITS(2), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rs(rs), .rt(rt), .sign_ext(sign_ext),
        .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .reg_dst(reg_dst),
        .rt_addr(rt_addr), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_out(pc_out), .rd_out(rd_out),
        .illegal_op(illegal_op), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0] pc, rs, rt, se;
        logic          src;
        logic [1:0]    op;
        logic          br, rdst;
        logic [AW-1:0] rta, rda;
    } in_t;

    typedef struct {
        logic [DW-1:0] res;
        logic          zero, taken;
        logic [DW-1:0] tgt, pco;
        logic [AW-1:0] rd;
        logic          ill;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, expected DUT event", nm);
    endtask

    function automatic in_t mkin(input logic [DW-1:0] p, a, b, s, input logic src,
                                 input logic [1:0] op, input logic br, rdst,
                                 input logic [AW-1:0] rta, rda);
        in_t v;
        v.pc = p; v.rs = a; v.rt = b; v.se = s; v.src = src; v.op = op;
        v.br = br; v.rdst = rdst; v.rta = rta; v.rda = rda;
        return v;
    endfunction

    function automatic exp_t mkexp(input logic [DW-1:0] r, input logic z, t,
                                   input logic [DW-1:0] tg, pco,
                                   input logic [AW-1:0] rd, input logic il);
        exp_t e;
        e.res = r; e.zero = z; e.taken = t; e.tgt = tg; e.pco = pco; e.rd = rd; e.ill = il;
        return e;
    endfunction

    // Reference model for the randomised section.
    function automatic exp_t model(input in_t v);
        exp_t          e;
        logic [DW-1:0] d2;
        logic [63:0]   prod;
        d2    = (v.op == 2'b00 || v.src) ? v.se : v.rt;
        e.ill = 1'b0;
        case (v.op)
            2'b00:   e.res = v.rs + d2;
            2'b01:   e.res = v.rs - d2;
            default: begin
                case (v.se[5:0])
                    6'd0: e.res = v.rs + d2;
                    6'd1: begin prod = {32'd0, v.rs} * {32'd0, d2}; e.res = prod[DW-1:0]; end
                    6'd2: e.res = v.rs - d2;
                    6'd3: e.res = v.rs & d2;
                    6'd4: e.res = v.rs | d2;
                    6'd5: e.res = ($signed(v.rs) < $signed(d2)) ? 32'd1 : 32'd0;
                    default: begin e.res = v.rs + d2; e.ill = 1'b1; end
                endcase
            end
        endcase
        e.zero  = (v.rs == d2);
        e.taken = v.br && e.zero;
        e.tgt   = v.pc + {v.se[DW-3:0], 2'b00};
        e.pco   = e.taken ? e.tgt : v.pc;
        e.rd    = v.rdst ? v.rda : v.rta;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input in_t v, input exp_t e, input bit push, output int waited);
        pc = v.pc; rs = v.rs; rt = v.rt; sign_ext = v.se; alu_src = v.src;
        alu_op = v.op; branch = v.br; reg_dst = v.rdst; rt_addr = v.rta; rd_addr = v.rda;
        in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rnd_bp) bp_rand = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : mon
        exp_t e;
        #3;
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got result %h, expected no output", result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("zero", zero, e.zero);
                chk("branch_taken", branch_taken, e.taken);
                chk("branch_target", branch_target, e.tgt);
                chk("pc_out", pc_out, e.pco);
                chk("rd_out", rd_out, e.rd);
                chk("illegal_op", illegal_op, e.ill);
            end
        end
    end

    vec_t tbl[14];

    initial begin
        int   w, bc, rdy_hi;
        in_t  v;
        exp_t e;

        tbl[0]  = '{mkin(32'h10, 5, 7, 0, 0, 2'b10, 0, 1, 2, 3), mkexp(12, 0, 0, 32'h10, 32'h10, 3, 0)};
        tbl[1]  = '{mkin(32'h40, 9, 9, 3, 0, 2'b01, 1, 0, 4, 8), mkexp(0, 1, 1, 32'h4C, 32'h4C, 4, 0)};
        tbl[2]  = '{mkin(32'h100, 32'hFFFFFFFF, 32'h55, 1, 0, 2'b00, 0, 0, 5, 9), mkexp(0, 0, 0, 32'h104, 32'h100, 5, 0)};
        tbl[3]  = '{mkin(32'h200, 32'hFFFFFFFF, 1, 5, 0, 2'b10, 0, 1, 1, 6), mkexp(1, 0, 0, 32'h214, 32'h200, 6, 0)};
        tbl[4]  = '{mkin(0, 10, 3, 32'h3F, 0, 2'b10, 0, 1, 1, 7), mkexp(13, 0, 0, 32'hFC, 0, 7, 1)};
        tbl[5]  = '{mkin(8, 3, 5, 2, 0, 2'b10, 0, 1, 1, 10), mkexp(32'hFFFFFFFE, 0, 0, 32'h10, 8, 10, 0)};
        tbl[6]  = '{mkin(0, 32'hF0F0, 32'hFF00, 3, 0, 2'b10, 0, 1, 1, 11), mkexp(32'hF000, 0, 0, 32'hC, 0, 11, 0)};
        tbl[7]  = '{mkin(32'h20, 32'h10, 32'h999, 4, 1, 2'b10, 0, 1, 1, 12), mkexp(32'h14, 0, 0, 32'h30, 32'h20, 12, 0)};
        tbl[8]  = '{mkin(32'h100, 1, 2, 32'hFFFFFFFE, 0, 2'b01, 1, 0, 13, 1), mkexp(32'hFFFFFFFF, 0, 0, 32'hF8, 32'h100, 13, 0)};
        tbl[9]  = '{mkin(0, 6, 7, 1, 0, 2'b10, 0, 1, 1, 14), mkexp(42, 0, 0, 4, 0, 14, 0)};
        tbl[10] = '{mkin(32'h1000, 8, 99, 8, 0, 2'b00, 1, 0, 15, 2), mkexp(16, 1, 1, 32'h1020, 32'h1020, 15, 0)};
        tbl[11] = '{mkin(0, 1, 32'hFFFFFFFF, 5, 0, 2'b10, 0, 1, 1, 16), mkexp(0, 0, 0, 32'h14, 0, 16, 0)};
        tbl[12] = '{mkin(0, 32'h10000, 32'h10001, 1, 0, 2'b10, 0, 1, 1, 17), mkexp(32'h10000, 0, 0, 4, 0, 17, 0)};
        tbl[13] = '{mkin(0, 32'hFFFFFFFF, 0, 1, 1, 2'b10, 0, 1, 1, 18), mkexp(32'hFFFFFFFF, 0, 0, 4, 0, 18, 0)};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; or_drv = 1'b1; rnd_bp = 1'b0; bp_rand = 1'b1;
        pc = '0; rs = '0; rt = '0; sign_ext = '0; alu_src = 1'b0; alu_op = 2'b00;
        branch = 1'b0; reg_dst = 1'b0; rt_addr = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_pc_out", pc_out, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);
        @(negedge clk);

        // Table-driven vectors, back-to-back with MEM always ready.
        for (int i = 0; i < 14; i++) send(tbl[i].i, tbl[i].e, 1'b1, w);

        // MUL occupancy: busy with in_ready low for the whole iteration.
        send(mkin(0, 6, 7, 1, 0, 2'b10, 0, 1, 1, 19), mkexp(42, 0, 0, 4, 0, 19, 0), 1'b1, w);
        bc = 0; rdy_hi = 0; w = 0;
        #1;
        while (busy && w < 100) begin
            if (in_ready) rdy_hi++;
            bc++;
            @(negedge clk);
            #1;
            w++;
        end
        chk("mul_busy_cycles", bc, 16);
        chk("mul_in_ready_high", rdy_hi, 0);
        @(negedge clk);

        // Backpressure on a MUL result, then back-to-back accept on release.
        or_drv = 1'b0;
        send(mkin(0, 3, 5, 1, 0, 2'b10, 0, 1, 1, 21), mkexp(15, 0, 0, 4, 0, 21, 0), 1'b1, w);
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!out_valid) fail_now("hold_out_valid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", result, 15);
            chk("hold_rd_out", rd_out, 21);
            chk("hold_in_ready", in_ready, 0);
        end
        or_drv = 1'b1;
        send(mkin(0, 20, 22, 0, 0, 2'b10, 0, 1, 1, 20), mkexp(42, 0, 0, 0, 0, 20, 0), 1'b1, w);
        chk("b2b_wait_cycles", w, 0);

        // Flush during MUL iteration 5.
        send(mkin(0, 9, 9, 1, 0, 2'b10, 0, 1, 1, 23), e, 1'b0, w);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", out_valid, 0);
        @(negedge clk);
        send(mkin(0, 1, 1, 0, 0, 2'b10, 0, 1, 1, 22), mkexp(2, 1, 0, 0, 0, 22, 0), 1'b1, w);
        repeat (25) @(negedge clk);

        // Reset while FULL under backpressure.
        or_drv = 1'b0;
        send(mkin(4, 3, 3, 32'h3F, 0, 2'b10, 1, 1, 1, 9), e, 1'b0, w);
        #1;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_result", result, 6);
        chk("pre_rst_taken", branch_taken, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_zero", zero, 0);
        chk("mid_rst_taken", branch_taken, 0);
        chk("mid_rst_illegal", illegal_op, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_pc_out", pc_out, 0);
        chk("mid_rst_target", branch_target, 0);
        chk("mid_rst_rd_out", rd_out, 0);
        or_drv = 1'b1;
        @(negedge clk);
        send(mkin(0, 2, 3, 0, 0, 2'b10, 0, 0, 5'h11, 5'h1E), mkexp(5, 0, 0, 0, 0, 5'h11, 0), 1'b1, w);

        // Randomised ops with random MEM backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [5:0] fl[8];
            fl = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'h3F, 6'h17};
            v = mkin($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                     $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom), 5'($urandom));
            v.se[5:0] = fl[$urandom_range(0, 7)];
            if (i % 4 == 0) v.rt = v.rs;
            send(v, model(v), 1'b1, w);
        end
        rnd_bp = 1'b0;
        or_drv = 1'b1;

        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
